// File: rtl/fwpic_irq_seq.sv
// fwpic_irq_seq: sequences a PIC interrupt over a simple register bus.
// Reads the vector register, hands the vector to the core, waits for the
// handler to finish, then writes the end-of-interrupt register.
// Optional watchdog (auto-EOI on a stuck handler): define FWPIC_IRQ_SEQ_TIMEOUT_EN.
module fwpic_irq_seq #(
  parameter int unsigned           ADR_WIDTH  = 4,
  parameter int unsigned           DAT_WIDTH  = 32,
  parameter logic [ADR_WIDTH-1:0]  VEC_ADR    = 4'h1,
  parameter logic [ADR_WIDTH-1:0]  EOI_ADR    = 4'h2,
  parameter int unsigned           TMO_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 int_i,
  output logic [ADR_WIDTH-1:0] adr,
  output logic [DAT_WIDTH-1:0] dat_w,
  input  logic [DAT_WIDTH-1:0] dat_r,
  output logic                 we,
  output logic                 valid,
  input  logic                 ready,
  output logic [7:0]           vec,
  output logic                 vec_valid,
  input  logic                 vec_ready,
  input  logic                 done_i,
  output logic                 busy,
  output logic [7:0]           spur_cnt,
  output logic                 timeout
);

  typedef enum logic [2:0] {
    IDLE,
    RD_VEC,
    DELIVER,
    WAIT_DONE,
    WR_EOI
  } state_e;

  state_e                 state_q, state_d;
  logic [ADR_WIDTH-1:0]   adr_q, adr_d;
  logic [DAT_WIDTH-1:0]   dat_w_q, dat_w_d;
  logic [7:0]             vec_q, vec_d;
  logic [7:0]             spur_cnt_q, spur_cnt_d;
  logic                   go_eoi;

  // Only the pending flag and the vector byte of the read data are used.
  logic unused_dat_r;
  assign unused_dat_r = ^dat_r[30:8];

`ifdef FWPIC_IRQ_SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TMO_CYCLES - 1);
  logic [15:0] wdog_q, wdog_d;
  logic        timeout_q, timeout_d;
`else
  logic [15:0] unused_tmo;
  assign unused_tmo = 16'(TMO_CYCLES);
`endif

  // Next-state, bus address/data hold registers, vector capture and spurious count.
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_w_d    = dat_w_q;
    vec_d      = vec_q;
    spur_cnt_d = spur_cnt_q;
    go_eoi     = 1'b0;
`ifdef FWPIC_IRQ_SEQ_TIMEOUT_EN
    timeout_d  = 1'b0;
    wdog_d     = '0;
`endif

    unique case (state_q)
      IDLE: begin
        if (int_i) begin
          state_d = RD_VEC;
          adr_d   = VEC_ADR;
        end
      end
      RD_VEC: begin
        if (ready) begin
          if (dat_r[31]) begin
            vec_d   = dat_r[7:0];
            state_d = DELIVER;
          end else begin
            if (spur_cnt_q != 8'hFF) spur_cnt_d = spur_cnt_q + 8'd1;
            state_d = IDLE;
          end
        end
      end
      DELIVER: begin
        if (vec_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_i) go_eoi = 1'b1;
      end
      WR_EOI: begin
        if (ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef FWPIC_IRQ_SEQ_TIMEOUT_EN
    // The watchdog spans DELIVER and WAIT_DONE as one window: it is zero on
    // arrival from RD_VEC and keeps counting across the DELIVER->WAIT_DONE step,
    // so expiry lands a fixed number of cycles after the vector is offered.
    if (state_q == DELIVER || state_q == WAIT_DONE) begin
      wdog_d = wdog_q + 16'd1;
      if (wdog_q == TMO_LIMIT) begin
        timeout_d = 1'b1;
        go_eoi    = 1'b1;
      end
    end
`endif

    if (go_eoi) begin
      state_d = WR_EOI;
      adr_d   = EOI_ADR;
      dat_w_d = DAT_WIDTH'(vec_q);
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      adr_q      <= '0;
      dat_w_q    <= '0;
      vec_q      <= '0;
      spur_cnt_q <= '0;
`ifdef FWPIC_IRQ_SEQ_TIMEOUT_EN
      wdog_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      dat_w_q    <= dat_w_d;
      vec_q      <= vec_d;
      spur_cnt_q <= spur_cnt_d;
`ifdef FWPIC_IRQ_SEQ_TIMEOUT_EN
      wdog_q     <= wdog_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign valid     = (state_q == RD_VEC) || (state_q == WR_EOI);
  assign we        = (state_q == WR_EOI);
  assign vec_valid = (state_q == DELIVER);
  assign busy      = (state_q != IDLE);
  assign adr       = adr_q;
  assign dat_w     = dat_w_q;
  assign vec       = vec_q;
  assign spur_cnt  = spur_cnt_q;
`ifdef FWPIC_IRQ_SEQ_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_fwpic_irq_seq.sv
// Directed testbench for fwpic_irq_seq.
module tb_fwpic_irq_seq;

  logic        clock;
  logic        reset;
  logic        int_i;
  logic [3:0]  adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        we;
  logic        valid;
  logic        ready;
  logic [7:0]  vec;
  logic        vec_valid;
  logic        vec_ready;
  logic        done_i;
  logic        busy;
  logic [7:0]  spur_cnt;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  // Bus/event monitors, sampled on the falling edge where everything is settled.
  int          xfer_cnt = 0;
  int          eoi_cnt  = 0;
  int          tmo_cnt  = 0;
  logic [31:0] eoi_dat  = '0;
  logic [3:0]  eoi_adr  = '0;

  fwpic_irq_seq #(
    .ADR_WIDTH (4),
    .DAT_WIDTH (32),
    .VEC_ADR   (4'h1),
    .EOI_ADR   (4'h2),
    .TMO_CYCLES(16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .int_i    (int_i),
    .adr      (adr),
    .dat_w    (dat_w),
    .dat_r    (dat_r),
    .we       (we),
    .valid    (valid),
    .ready    (ready),
    .vec      (vec),
    .vec_valid(vec_valid),
    .vec_ready(vec_ready),
    .done_i   (done_i),
    .busy     (busy),
    .spur_cnt (spur_cnt),
    .timeout  (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset && valid && ready) begin
      xfer_cnt++;
      if (we) begin
        eoi_cnt++;
        eoi_dat = dat_w;
        eoi_adr = adr;
      end
    end
    if (timeout) tmo_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL tb_time_limit got running exp finished");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", we); end
    checks++; if (vec_valid !== 1'b0) begin errors++; $display("FAIL reset_vec_valid got %0b exp 0", vec_valid); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0b exp 0", timeout); end
    checks++; if (vec !== 8'h00) begin errors++; $display("FAIL reset_vec got %h exp 00", vec); end
    checks++; if (adr !== 4'h0) begin errors++; $display("FAIL reset_adr got %h exp 0", adr); end
    checks++; if (dat_w !== 32'h0) begin errors++; $display("FAIL reset_dat_w got %h exp 0", dat_w); end
    checks++; if (spur_cnt !== 8'h00) begin errors++; $display("FAIL reset_spur_cnt got %h exp 00", spur_cnt); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    ready = 1'b1; vec_ready = 1'b1; dat_r = 32'h8000_0005;
    // done_i outside WAIT_DONE must be ignored
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_done_ignored busy got %0b exp 0", busy); end
    int_i = 1'b1;
    step();
    int_i = 1'b0;
    checks++; if ({valid, we, adr} !== {1'b1, 1'b0, 4'h1}) begin errors++; $display("FAIL basic_rd valid/we/adr got %b/%b/%h exp 1/0/1", valid, we, adr); end
    checks++; if (vec_valid !== 1'b0) begin errors++; $display("FAIL basic_rd_vec_valid got %0b exp 0", vec_valid); end
    step();
    checks++; if ({vec_valid, vec} !== {1'b1, 8'h05}) begin errors++; $display("FAIL basic_latency vec_valid/vec got %b/%h exp 1/05", vec_valid, vec); end
    checks++; if ({valid, we} !== 2'b00) begin errors++; $display("FAIL basic_deliver_bus valid/we got %b/%b exp 0/0", valid, we); end
    step();
    checks++; if ({vec_valid, busy} !== 2'b01) begin errors++; $display("FAIL basic_wait vec_valid/busy got %b/%b exp 0/1", vec_valid, busy); end
    step();
    step();
    checks++; if ({busy, valid} !== 2'b10) begin errors++; $display("FAIL basic_wait_hold busy/valid got %b/%b exp 1/0", busy, valid); end
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    checks++; if ({valid, we, adr} !== {1'b1, 1'b1, 4'h2}) begin errors++; $display("FAIL basic_eoi valid/we/adr got %b/%b/%h exp 1/1/2", valid, we, adr); end
    checks++; if (dat_w !== 32'h0000_0005) begin errors++; $display("FAIL basic_eoi_dat got %h exp 00000005", dat_w); end
    step();
    checks++; if ({busy, valid, we} !== 3'b000) begin errors++; $display("FAIL basic_end busy/valid/we got %b/%b/%b exp 0/0/0", busy, valid, we); end
    checks++; if ({adr, dat_w} !== {4'h2, 32'h0000_0005}) begin errors++; $display("FAIL basic_hold adr/dat_w got %h/%h exp 2/00000005", adr, dat_w); end
  endtask

  task automatic test_spurious();
    logic saw_vv;
    saw_vv = 1'b0;
    ready = 1'b1; dat_r = 32'h0000_0000;
    int_i = 1'b1;
    step();
    step();
    checks++; if (spur_cnt !== 8'h01) begin errors++; $display("FAIL spur_first got %h exp 01", spur_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spur_idle busy got %0b exp 0", busy); end
    for (int n = 2; n <= 256; n++) begin
      step();
      if (vec_valid) saw_vv = 1'b1;
      step();
      if (vec_valid) saw_vv = 1'b1;
      if (n == 254) begin
        checks++; if (spur_cnt !== 8'hFE) begin errors++; $display("FAIL spur_254 got %h exp fe", spur_cnt); end
      end
      if (n == 255) begin
        checks++; if (spur_cnt !== 8'hFF) begin errors++; $display("FAIL spur_255 got %h exp ff", spur_cnt); end
      end
    end
    int_i = 1'b0;
    checks++; if (spur_cnt !== 8'hFF) begin errors++; $display("FAIL spur_saturate got %h exp ff", spur_cnt); end
    checks++; if (saw_vv !== 1'b0) begin errors++; $display("FAIL spur_no_vec_valid got %0b exp 0", saw_vv); end
    checks++; if (vec !== 8'h05) begin errors++; $display("FAIL spur_vec_kept got %h exp 05", vec); end
    step();
  endtask

  task automatic test_stall();
    int  x0, e0;
    logic bad;
    x0 = xfer_cnt; e0 = eoi_cnt;
    vec_ready = 1'b1; dat_r = 32'h8000_0007; ready = 1'b0;
    int_i = 1'b1;
    step();
    int_i = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if ({valid, we, adr} !== {1'b1, 1'b0, 4'h1}) bad = 1'b1;
      step();
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL stall_rd_hold got unstable exp stable valid=%b we=%b adr=%h", valid, we, adr); end
    checks++; if ({valid, vec_valid} !== 2'b10) begin errors++; $display("FAIL stall_rd_wait valid/vec_valid got %b/%b exp 1/0", valid, vec_valid); end
    ready = 1'b1;
    step();
    checks++; if ({vec_valid, vec} !== {1'b1, 8'h07}) begin errors++; $display("FAIL stall_deliver got %b/%h exp 1/07", vec_valid, vec); end
    step();
    done_i = 1'b1; ready = 1'b0;
    step();
    done_i = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if ({valid, we, adr, dat_w} !== {1'b1, 1'b1, 4'h2, 32'h0000_0007}) bad = 1'b1;
      step();
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL stall_eoi_hold got unstable exp stable valid=%b we=%b adr=%h", valid, we, adr); end
    ready = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_end busy got %0b exp 0", busy); end
    checks++; if (xfer_cnt - x0 !== 2) begin errors++; $display("FAIL stall_xfers got %0d exp 2", xfer_cnt - x0); end
    checks++; if (eoi_cnt - e0 !== 1) begin errors++; $display("FAIL stall_eois got %0d exp 1", eoi_cnt - e0); end
  endtask

  task automatic test_reset_mid();
    int e0;
    e0 = eoi_cnt;
    ready = 1'b1; vec_ready = 1'b1; dat_r = 32'h8000_0003;
    int_i = 1'b1;
    step();
    int_i = 1'b0;
    step();
    step();
    checks++; if ({busy, vec_valid, vec} !== {1'b1, 1'b0, 8'h03}) begin errors++; $display("FAIL rstmid_wait busy/vv/vec got %b/%b/%h exp 1/0/03", busy, vec_valid, vec); end
    reset = 1'b0;
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    checks++; if ({busy, valid, we, vec_valid, timeout} !== 5'b00000) begin errors++; $display("FAIL rstmid_ctrl got %b%b%b%b%b exp 00000", busy, valid, we, vec_valid, timeout); end
    checks++; if ({vec, adr, dat_w, spur_cnt} !== '0) begin errors++; $display("FAIL rstmid_data vec/adr/dat_w/spur got %h/%h/%h/%h exp 0", vec, adr, dat_w, spur_cnt); end
    reset = 1'b1;
    step();
    step();
    step();
    checks++; if ({busy, eoi_cnt - e0} !== {1'b0, 32'd0}) begin errors++; $display("FAIL rstmid_no_eoi busy/eois got %b/%0d exp 0/0", busy, eoi_cnt - e0); end
    int_i = 1'b1;
    step();
    int_i = 1'b0;
    checks++; if ({valid, we, adr} !== {1'b1, 1'b0, 4'h1}) begin errors++; $display("FAIL rstmid_reread got %b/%b/%h exp 1/0/1", valid, we, adr); end
    step();
    step();
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    step();
    checks++; if ({eoi_cnt - e0, eoi_dat} !== {32'd1, 32'h0000_0003}) begin errors++; $display("FAIL rstmid_eoi eois/dat got %0d/%h exp 1/00000003", eoi_cnt - e0, eoi_dat); end
  endtask

  task automatic test_timeout();
    int t0, e0;
    t0 = tmo_cnt; e0 = eoi_cnt;
    ready = 1'b1; vec_ready = 1'b1; dat_r = 32'h8000_0009;
    int_i = 1'b1;
    step();
    int_i = 1'b0;
    step();
`ifdef FWPIC_IRQ_SEQ_TIMEOUT_EN
    for (int i = 1; i < 16; i++) step();
    checks++; if (tmo_cnt - t0 !== 0) begin errors++; $display("FAIL tmo_early got %0d exp 0", tmo_cnt - t0); end
    step();
    checks++; if ({timeout, vec_valid} !== 2'b10) begin errors++; $display("FAIL tmo_pulse timeout/vv got %b/%b exp 1/0", timeout, vec_valid); end
    checks++; if ({valid, we, adr, dat_w} !== {1'b1, 1'b1, 4'h2, 32'h0000_0009}) begin errors++; $display("FAIL tmo_eoi got %b/%b/%h/%h exp 1/1/2/00000009", valid, we, adr, dat_w); end
    step();
    checks++; if ({timeout, busy} !== 2'b00) begin errors++; $display("FAIL tmo_end timeout/busy got %b/%b exp 0/0", timeout, busy); end
`else
    for (int i = 0; i < 40; i++) step();
    checks++; if ({busy, valid, vec_valid} !== 3'b100) begin errors++; $display("FAIL notmo_wait busy/valid/vv got %b/%b/%b exp 1/0/0", busy, valid, vec_valid); end
    checks++; if (tmo_cnt - t0 !== 0) begin errors++; $display("FAIL notmo_timeout got %0d exp 0", tmo_cnt - t0); end
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    step();
`endif
    checks++; if ({eoi_cnt - e0, eoi_dat} !== {32'd1, 32'h0000_0009}) begin errors++; $display("FAIL tmo_eoi_seen eois/dat got %0d/%h exp 1/00000009", eoi_cnt - e0, eoi_dat); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    ready = 1'b1; vec_ready = 1'b1;
    int_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      v = 8'(i);
      dat_r = {24'h80_0000, v};
      step();
      checks++; if ({valid, we, adr} !== {1'b1, 1'b0, 4'h1}) begin errors++; $display("FAIL b2b_rd%0d got %b/%b/%h exp 1/0/1", i, valid, we, adr); end
      step();
      checks++; if ({vec_valid, vec} !== {1'b1, v}) begin errors++; $display("FAIL b2b_vec%0d got %b/%h exp 1/%h", i, vec_valid, vec, v); end
      step();
      done_i = 1'b1;
      step();
      done_i = 1'b0;
      checks++; if ({we, dat_w} !== {1'b1, 24'h0, v}) begin errors++; $display("FAIL b2b_eoi%0d got %b/%h exp 1/%h", i, we, dat_w, v); end
      if (i == 3) int_i = 1'b0;
      step();
      checks++; if ({busy, eoi_dat} !== {1'b0, 24'h0, v}) begin errors++; $display("FAIL b2b_idle%0d busy/eoi got %b/%h exp 0/%h", i, busy, eoi_dat, v); end
    end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end busy got %0b exp 0", busy); end
  endtask

  initial begin
    reset = 1'b0; int_i = 1'b0; dat_r = '0; ready = 1'b0;
    vec_ready = 1'b0; done_i = 1'b0;
    test_reset();
    test_basic();
    test_spurious();
    test_stall();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
